// File: rtl/fetch_stage.sv
// Instruction fetch front-end: owns the PC, drives the instruction ROM address and
// presents each fetched word to decode through a one-entry IF/ID slot with valid/ready.
module fetch_stage #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INST_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [ADDR_W-1:0]  PC_STEP  = ADDR_W'(1),
    parameter logic [INST_W-1:0]  NOP_INST = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic [INST_W-1:0] inst_data,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [INST_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    input  logic              resume,
    output logic              halted,
    output logic [31:0]       fetch_count
);

    localparam logic [1:0] BOOT   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              id_valid_q, id_valid_d;
    logic [INST_W-1:0] id_inst_q, id_inst_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [31:0]       fetch_count_q, fetch_count_d;
    logic              advance;

    assign advance = !id_valid_q || id_ready;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_inst_d     = id_inst_q;
        id_pc_d       = id_pc_q;
        fetch_count_d = fetch_count_q;
        case (state_q)
            HALTED: begin
                // No new fetches; the occupied slot still drains to decode.
                if (id_valid_q && id_ready) begin
                    id_valid_d = 1'b0;
                    id_inst_d  = NOP_INST;
                end
                if (resume && !halt_req) begin
                    state_d = RUN;
                end
            end
            default: begin
                if (redirect_valid) begin
                    pc_d       = redirect_pc;
                    id_valid_d = 1'b0;
                    id_inst_d  = NOP_INST;
                end else if (state_q == RUN && advance) begin
                    id_inst_d     = inst_data;
                    id_pc_d       = pc_q;
                    id_valid_d    = 1'b1;
                    pc_d          = pc_q + PC_STEP;
                    fetch_count_d = fetch_count_q + 32'd1;
                end
                // Halt lands after this cycle's fetch or redirect has been applied.
                state_d = halt_req ? HALTED : RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_inst_q     <= NOP_INST;
            id_pc_q       <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_inst_q     <= id_inst_d;
            id_pc_q       <= id_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign inst_addr   = pc_q;
    assign id_valid    = id_valid_q;
    assign id_inst     = id_inst_q;
    assign id_pc       = id_pc_q;
    assign halted      = (state_q == HALTED);
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a ROM model returns 100+address, expected
// (pc, inst) pairs are queued as fetches are provoked and checked on each handshake.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        resume;
    logic        halted;
    logic [31:0] fetch_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    assign inst_data = 32'd100 + inst_addr;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .inst_addr      (inst_addr),
        .inst_data      (inst_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .resume         (resume),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        logic [31:0] inst;
        inst = 32'd100 + pc;
        sb_q.push_back({pc, inst});
    endtask

    // Consume a pending handshake against the scoreboard, then advance one clock.
    task automatic step();
        logic [63:0] e;
        if (id_valid && id_ready) begin
            chk("sb_underflow", 64'(sb_q.size() == 0), 64'd0);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                $display("accept pc=%08h inst=%08h (exp pc=%08h inst=%08h)",
                         id_pc, id_inst, e[63:32], e[31:0]);
                chk("acc_pc", 64'(id_pc), 64'(e[63:32]));
                chk("acc_inst", 64'(id_inst), 64'(e[31:0]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_req       = 1'b0;
        resume         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", 64'(inst_addr), 64'd0);
        chk("rst_valid", 64'(id_valid), 64'd0);
        chk("rst_inst", 64'(id_inst), 64'd0);
        chk("rst_idpc", 64'(id_pc), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_count", 64'(fetch_count), 64'd0);

        // Streaming after reset: one BOOT bubble then 1 instr/cycle.
        rst      = 1'b0;
        id_ready = 1'b1;
        for (int k = 0; k < 4; k++) push_exp(32'(k));
        step();
        chk("boot_bubble", 64'(id_valid), 64'd0);
        chk("boot_addr", 64'(inst_addr), 64'd0);
        step();
        chk("first_valid", 64'(id_valid), 64'd1);
        chk("first_pc", 64'(id_pc), 64'd0);
        repeat (3) step();
        chk("stream_count", 64'(fetch_count), 64'd4);
        chk("stream_addr", 64'(inst_addr), 64'd4);

        // Decode back-pressure: slot and PC freeze.
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", 64'(id_valid), 64'd1);
            chk("stall_pc", 64'(id_pc), 64'd3);
            chk("stall_inst", 64'(id_inst), 64'd103);
            chk("stall_addr", 64'(inst_addr), 64'd4);
        end
        id_ready = 1'b1;
        push_exp(32'd4);
        step();
        chk("release_pc", 64'(id_pc), 64'd4);
        step();

        // Redirect while stalled discards the slot.
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        chk("redir_valid", 64'(id_valid), 64'd0);
        chk("redir_inst", 64'(id_inst), 64'd0);
        chk("redir_addr", 64'(inst_addr), 64'h40);
        chk("redir_count", 64'(fetch_count), 64'd6);
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        push_exp(32'h40);
        push_exp(32'h41);
        step();
        chk("redir_target", 64'(id_pc), 64'h40);
        chk("redir_count2", 64'(fetch_count), 64'd7);
        step();

        // Halt at pc=5: one more issue, then PC holds.
        redirect_valid = 1'b1;
        redirect_pc    = 32'd5;
        step();
        redirect_valid = 1'b0;
        halt_req       = 1'b1;
        push_exp(32'd5);
        step();
        halt_req = 1'b0;
        chk("halt_flag", 64'(halted), 64'd1);
        chk("halt_lastpc", 64'(id_pc), 64'd5);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt_addr", 64'(inst_addr), 64'd6);
            chk("halt_hold", 64'(halted), 64'd1);
        end
        chk("halt_drained", 64'(id_valid), 64'd0);
        chk("halt_count", 64'(fetch_count), 64'd9);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h99;
        step();
        redirect_valid = 1'b0;
        chk("halt_redir_ignored", 64'(inst_addr), 64'd6);
        halt_req = 1'b1;
        resume   = 1'b1;
        step();
        chk("halt_resume_both", 64'(halted), 64'd1);
        halt_req = 1'b0;
        push_exp(32'd6);
        step();
        resume = 1'b0;
        chk("resume_flag", 64'(halted), 64'd0);
        step();
        chk("resume_pc", 64'(id_pc), 64'd6);
        chk("resume_valid", 64'(id_valid), 64'd1);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        step();
        redirect_valid = 1'b0;
        chk("wrap_addr", 64'(inst_addr), 64'hFFFF_FFFF);
        push_exp(32'hFFFF_FFFF);
        push_exp(32'h0);
        push_exp(32'h1);
        repeat (4) step();
        chk("wrap_count", 64'(fetch_count), 64'd14);
        chk("wrap_next_addr", 64'(inst_addr), 64'd3);
        chk("sb_empty1", 64'(sb_q.size()), 64'd0);

        // Asynchronous reset between clock edges.
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(id_valid), 64'd0);
        chk("arst_addr", 64'(inst_addr), 64'd0);
        chk("arst_idpc", 64'(id_pc), 64'd0);
        chk("arst_inst", 64'(id_inst), 64'd0);
        chk("arst_count", 64'(fetch_count), 64'd0);
        chk("arst_halted", 64'(halted), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_exp(32'd0);
        step();
        chk("arst_bubble", 64'(id_valid), 64'd0);
        step();
        chk("arst_first_pc", 64'(id_pc), 64'd0);
        chk("arst_first_valid", 64'(id_valid), 64'd1);
        step();
        chk("sb_empty2", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
